// File: rtl/even_fx_pipe.sv
// Even-pipe fixed-point/logical SIMD execution unit: lane arithmetic, LATENCY-deep result
// pipeline with per-stage forwarding taps, flush, illegal-op pulse and retire counter.
module even_fx_pipe #(
    parameter int unsigned DATA_W  = 128,
    parameter int unsigned LATENCY = 2,
    parameter int unsigned ADDR_W  = 7
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        in_valid,
    input  logic [3:0]                  op_sel,
    input  logic                        hw_mode,
    input  logic [DATA_W-1:0]           ra_input,
    input  logic [DATA_W-1:0]           rb_input,
    input  logic [9:0]                  I10_input,
    input  logic [ADDR_W-1:0]           rt_address_input,
    input  logic                        flush,
    output logic                        wrt_en,
    output logic [ADDR_W-1:0]           rt_address,
    output logic [DATA_W-1:0]           rt_value,
    output logic [LATENCY-1:0]          fwd_valid,
    output logic [ADDR_W*LATENCY-1:0]   fwd_addr,
    output logic [DATA_W*LATENCY-1:0]   fwd_data,
    output logic                        illegal_op,
    output logic [31:0]                 retired
);

    localparam int unsigned NumWords = DATA_W / 32;
    localparam int unsigned NumHalfs = DATA_W / 16;

    localparam logic [3:0] OpAdd  = 4'd1;
    localparam logic [3:0] OpSf   = 4'd2;
    localparam logic [3:0] OpAddi = 4'd3;
    localparam logic [3:0] OpSfi  = 4'd4;
    localparam logic [3:0] OpCg   = 4'd5;
    localparam logic [3:0] OpBg   = 4'd6;
    localparam logic [3:0] OpAnd  = 4'd7;
    localparam logic [3:0] OpAndc = 4'd8;
    localparam logic [3:0] OpOr   = 4'd9;
    localparam logic [3:0] OpXor  = 4'd10;

    logic [31:0]       w_sext32;
    logic [15:0]       w_sext16;
    logic [DATA_W-1:0] w_word_res;
    logic [DATA_W-1:0] w_half_res;
    logic [DATA_W-1:0] w_result;
    logic              w_legal;
    logic              w_capture;

    assign w_sext32 = {{22{I10_input[9]}}, I10_input};
    assign w_sext16 = {{6{I10_input[9]}}, I10_input};

    // Each 32-bit slice has its own adder; lane order only affects placement.
    for (genvar gi = 0; gi < NumWords; gi++) begin : g_word
        logic [31:0] w_a;
        logic [31:0] w_b;
        logic [32:0] w_sum;
        logic [31:0] w_res;

        assign w_a   = ra_input[gi*32 +: 32];
        assign w_b   = rb_input[gi*32 +: 32];
        assign w_sum = {1'b0, w_a} + {1'b0, w_b};

        // Word-lane arithmetic, including carry/borrow generate
        always_comb begin
            w_res = '0;
            case (op_sel)
                OpAdd:   w_res = w_sum[31:0];
                OpSf:    w_res = w_b - w_a;
                OpAddi:  w_res = w_a + w_sext32;
                OpSfi:   w_res = w_sext32 - w_a;
                OpCg:    w_res = {31'b0, w_sum[32]};
                OpBg:    w_res = {31'b0, (w_b >= w_a)};
                default: w_res = '0;
            endcase
        end

        assign w_word_res[gi*32 +: 32] = w_res;
    end

    for (genvar gi = 0; gi < NumHalfs; gi++) begin : g_half
        logic [15:0] w_a;
        logic [15:0] w_b;
        logic [15:0] w_res;

        assign w_a = ra_input[gi*16 +: 16];
        assign w_b = rb_input[gi*16 +: 16];

        // Halfword-lane arithmetic; CG/BG have no halfword form
        always_comb begin
            w_res = '0;
            case (op_sel)
                OpAdd:   w_res = w_a + w_b;
                OpSf:    w_res = w_b - w_a;
                OpAddi:  w_res = w_a + w_sext16;
                OpSfi:   w_res = w_sext16 - w_a;
                default: w_res = '0;
            endcase
        end

        assign w_half_res[gi*16 +: 16] = w_res;
    end

    // Final result select: lane width for arithmetic, full-width for logicals
    always_comb begin
        w_result = '0;
        case (op_sel)
            OpAdd, OpSf, OpAddi, OpSfi: w_result = hw_mode ? w_half_res : w_word_res;
            OpCg, OpBg:                 w_result = w_word_res;
            OpAnd:                      w_result = ra_input & rb_input;
            OpAndc:                     w_result = ra_input & ~rb_input;
            OpOr:                       w_result = ra_input | rb_input;
            OpXor:                      w_result = ra_input ^ rb_input;
            default:                    w_result = '0;
        endcase
    end

    assign w_legal   = (op_sel >= OpAdd) && (op_sel <= OpXor);
    assign w_capture = in_valid && w_legal && !flush;

    logic              r_valid [LATENCY];
    logic [ADDR_W-1:0] r_addr  [LATENCY];
    logic [DATA_W-1:0] r_data  [LATENCY];
    logic              r_illegal;
    logic [31:0]       r_retired;

    // Stage 1 capture; addr/data hold while the stage is empty
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_valid[0] <= 1'b0;
            r_addr[0]  <= '0;
            r_data[0]  <= '0;
        end else begin
            r_valid[0] <= w_capture;
            if (w_capture) begin
                r_addr[0] <= rt_address_input;
                r_data[0] <= w_result;
            end
        end
    end

    for (genvar gk = 1; gk < LATENCY; gk++) begin : g_stage
        // Stage gk+1 follows stage gk; flush kills the valid in flight
        always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
                r_valid[gk] <= 1'b0;
                r_addr[gk]  <= '0;
                r_data[gk]  <= '0;
            end else begin
                r_valid[gk] <= r_valid[gk-1] && !flush;
                r_addr[gk]  <= r_addr[gk-1];
                r_data[gk]  <= r_data[gk-1];
            end
        end
    end

    // Illegal-op pulse reports even when flush drops the instruction
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_illegal <= 1'b0;
        end else begin
            r_illegal <= in_valid && (op_sel > OpXor);
        end
    end

    // Count completed write-backs; wraps naturally
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_retired <= '0;
        end else if (r_valid[LATENCY-1]) begin
            r_retired <= r_retired + 32'd1;
        end
    end

    for (genvar gk = 0; gk < LATENCY; gk++) begin : g_fwd
        assign fwd_valid[gk]                    = r_valid[gk];
        assign fwd_addr[gk*ADDR_W +: ADDR_W]    = r_addr[gk];
        assign fwd_data[gk*DATA_W +: DATA_W]    = r_data[gk];
    end

    assign wrt_en     = r_valid[LATENCY-1];
    assign rt_address = r_addr[LATENCY-1];
    assign rt_value   = r_data[LATENCY-1];
    assign illegal_op = r_illegal;
    assign retired    = r_retired;

endmodule

// File: tb/tb_even_fx_pipe.sv
// Bench for even_fx_pipe: three instances (LATENCY 2, 1, 5) share one stimulus stream and are
// checked every cycle against a per-edge issue log, plus literal spot checks.
module tb_even_fx_pipe;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic         in_valid = 1'b0;
    logic [3:0]   op_sel = 4'd0;
    logic         hw_mode = 1'b0;
    logic [127:0] ra_in = '0;
    logic [127:0] rb_in = '0;
    logic [9:0]   i10 = '0;
    logic [6:0]   addr_in = '0;
    logic         flush = 1'b0;

    logic         wrt2, wrt1, wrt5;
    logic [6:0]   rta2, rta1, rta5;
    logic [127:0] rtv2, rtv1, rtv5;
    logic [1:0]   fv2;
    logic [0:0]   fv1;
    logic [4:0]   fv5;
    logic [13:0]  fa2;
    logic [6:0]   fa1;
    logic [34:0]  fa5;
    logic [255:0] fd2;
    logic [127:0] fd1;
    logic [639:0] fd5;
    logic         ill2, ill1, ill5;
    logic [31:0]  ret2, ret1, ret5;

    int n_tests = 0;
    int n_fail  = 0;
    bit checking = 1'b0;

    always #5 clock = ~clock;

    even_fx_pipe #(.DATA_W(128), .LATENCY(2), .ADDR_W(7)) dut_l2 (
        .clock(clock), .reset(reset), .in_valid(in_valid), .op_sel(op_sel), .hw_mode(hw_mode),
        .ra_input(ra_in), .rb_input(rb_in), .I10_input(i10), .rt_address_input(addr_in),
        .flush(flush), .wrt_en(wrt2), .rt_address(rta2), .rt_value(rtv2), .fwd_valid(fv2),
        .fwd_addr(fa2), .fwd_data(fd2), .illegal_op(ill2), .retired(ret2));

    even_fx_pipe #(.DATA_W(128), .LATENCY(1), .ADDR_W(7)) dut_l1 (
        .clock(clock), .reset(reset), .in_valid(in_valid), .op_sel(op_sel), .hw_mode(hw_mode),
        .ra_input(ra_in), .rb_input(rb_in), .I10_input(i10), .rt_address_input(addr_in),
        .flush(flush), .wrt_en(wrt1), .rt_address(rta1), .rt_value(rtv1), .fwd_valid(fv1),
        .fwd_addr(fa1), .fwd_data(fd1), .illegal_op(ill1), .retired(ret1));

    even_fx_pipe #(.DATA_W(128), .LATENCY(5), .ADDR_W(7)) dut_l5 (
        .clock(clock), .reset(reset), .in_valid(in_valid), .op_sel(op_sel), .hw_mode(hw_mode),
        .ra_input(ra_in), .rb_input(rb_in), .I10_input(i10), .rt_address_input(addr_in),
        .flush(flush), .wrt_en(wrt5), .rt_address(rta5), .rt_value(rtv5), .fwd_valid(fv5),
        .fwd_addr(fa5), .fwd_data(fd5), .illegal_op(ill5), .retired(ret5));

    // ---------------- reference model ----------------
    // Result of one instruction, computed lane by lane with plain integer arithmetic.
    function automatic logic [127:0] model_result(input logic [3:0] op, input logic hw,
                                                  input logic [127:0] a, input logic [127:0] b,
                                                  input logic [9:0] imm10);
        logic [127:0]    res;
        longint          simm;
        longint unsigned la, lb, limm, mask, r;
        int              lw, sh;
        res = '0;
        case (op)
            4'd7:  return a & b;
            4'd8:  return a & ~b;
            4'd9:  return a | b;
            4'd10: return a ^ b;
            default: ;
        endcase
        if (op < 4'd1 || op > 4'd6) return '0;
        lw   = (hw && op <= 4'd4) ? 16 : 32;
        mask = (64'd1 << lw) - 64'd1;
        simm = longint'($signed(imm10));
        limm = longint'(simm) & mask;
        for (int i = 0; i < 128 / lw; i++) begin
            sh = 128 - (i + 1) * lw;
            la = 64'(a >> sh) & mask;
            lb = 64'(b >> sh) & mask;
            case (op)
                4'd1:    r = la + lb;
                4'd2:    r = lb - la;
                4'd3:    r = la + limm;
                4'd4:    r = limm - la;
                4'd5:    r = (la + lb) >> 32;
                default: r = (lb >= la) ? 64'd1 : 64'd0;
            endcase
            r   = r & mask;
            res = res | (128'(r) << sh);
        end
        return res;
    endfunction

    // Issue log indexed by clock edge number; anything at or before last_kill is dead.
    int           e = 0;
    int           last_kill = 0;
    bit           cap_v [4096];
    logic [6:0]   cap_a [4096];
    logic [127:0] cap_d [4096];
    logic         ill_exp = 1'b0;
    logic [31:0]  ret_exp [3] = '{32'd0, 32'd0, 32'd0};
    int           lat [3] = '{2, 1, 5};

    // Instruction captured at edge j sits in stage k after edge j+k-1.
    function automatic bit exp_valid(input int ee, input int k);
        int j;
        j = ee - k + 1;
        if (j < 1 || j <= last_kill) return 1'b0;
        return cap_v[j];
    endfunction

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            last_kill = e;
            ill_exp   = 1'b0;
            for (int i = 0; i < 3; i++) ret_exp[i] = 32'd0;
        end else begin
            for (int i = 0; i < 3; i++) if (exp_valid(e, lat[i])) ret_exp[i] = ret_exp[i] + 1;
            ill_exp = in_valid && (op_sel >= 4'd11);
            e = e + 1;
            cap_v[e] = in_valid && (op_sel >= 4'd1) && (op_sel <= 4'd10) && !flush;
            cap_a[e] = addr_in;
            cap_d[e] = model_result(op_sel, hw_mode, ra_in, rb_in, i10);
            if (flush) last_kill = e;
        end
    end

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic check_dut(input string nm, input int L, input int idx, input logic [7:0] fv,
                             input logic [55:0] fa, input logic [1023:0] fd, input logic wrt,
                             input logic [6:0] rta, input logic [127:0] rtv, input logic ill,
                             input logic [31:0] ret);
        logic [7:0] ev;
        int         j;
        ev = '0;
        for (int k = 1; k <= L; k++) ev[k-1] = exp_valid(e, k);
        chk({nm, ".fwd_valid"}, 128'(fv), 128'(ev));
        chk({nm, ".wrt_en"}, 128'(wrt), 128'(ev[L-1]));
        for (int k = 1; k <= L; k++) begin
            if (ev[k-1]) begin
                j = e - k + 1;
                chk($sformatf("%s.fwd_addr[%0d]", nm, k), 128'(fa[(k-1)*7 +: 7]), 128'(cap_a[j]));
                chk($sformatf("%s.fwd_data[%0d]", nm, k), fd[(k-1)*128 +: 128], cap_d[j]);
            end
        end
        if (ev[L-1]) begin
            j = e - L + 1;
            chk({nm, ".rt_address"}, 128'(rta), 128'(cap_a[j]));
            chk({nm, ".rt_value"}, rtv, cap_d[j]);
        end
        chk({nm, ".illegal_op"}, 128'(ill), 128'(ill_exp));
        chk({nm, ".retired"}, 128'(ret), 128'(ret_exp[idx]));
    endtask

    // Every-cycle comparison of all three instances against the model
    always @(negedge clock) begin
        if (checking && !reset) begin
            check_dut("L2", 2, 0, 8'(fv2), 56'(fa2), 1024'(fd2), wrt2, rta2, rtv2, ill2, ret2);
            check_dut("L1", 1, 1, 8'(fv1), 56'(fa1), 1024'(fd1), wrt1, rta1, rtv1, ill1, ret1);
            check_dut("L5", 5, 2, 8'(fv5), 56'(fa5), 1024'(fd5), wrt5, rta5, rtv5, ill5, ret5);
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic issue(input logic [3:0] op, input logic hw, input logic [127:0] a,
                         input logic [127:0] b, input logic [9:0] imm, input logic [6:0] ad);
        in_valid = 1'b1;
        op_sel   = op;
        hw_mode  = hw;
        ra_in    = a;
        rb_in    = b;
        i10      = imm;
        addr_in  = ad;
        @(negedge clock);
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        op_sel   = 4'd0;
        flush    = 1'b0;
        repeat (n) @(negedge clock);
    endtask

    initial begin
        repeat (2) @(negedge clock);
        chk("reset.wrt_en", 128'(wrt2), 128'd0);
        chk("reset.rt_value", rtv2, 128'd0);
        chk("reset.fwd_valid5", 128'(fv5), 128'd0);
        chk("reset.retired", 128'(ret2), 128'd0);
        reset    = 1'b0;
        checking = 1'b1;
        idle(1);

        // ADD word across all latencies
        issue(4'd1, 1'b0, 128'd20, 128'd10, 10'd0, 7'd5);
        chk("t1.fwd_valid_e1", 128'(fv2), 128'(2'b01));
        chk("t1.l1_value", rtv1, 128'd30);
        idle(1);
        chk("t1.wrt_en", 128'(wrt2), 128'd1);
        chk("t1.value", rtv2, 128'd30);
        chk("t1.addr", 128'(rta2), 128'd5);
        idle(3);
        chk("t1.l5_wrt_en", 128'(wrt5), 128'd1);
        chk("t1.l5_value", rtv5, 128'd30);
        idle(2);

        // Halfword SF / ADDI
        issue(4'd2, 1'b1, 128'd21, 128'd56, 10'd0, 7'd6);
        issue(4'd3, 1'b1, 128'd15, 128'd0, 10'h3FF, 7'd7);
        chk("t2.sf_hw", rtv2, 128'd35);
        idle(1);
        chk("t2.addi_hw", rtv2, {{7{16'hFFFF}}, 16'd14});
        idle(5);

        // SFI word, CG, BG
        issue(4'd4, 1'b0, 128'd25, 128'd0, 10'd100, 7'd8);
        issue(4'd5, 1'b1, 128'hFFFF_FFFF, 128'd1, 10'd0, 7'd9);
        chk("t3.sfi", rtv2, {32'd100, 32'd100, 32'd100, 32'd75});
        issue(4'd6, 1'b1, 128'd25, 128'd45, 10'd0, 7'd10);
        chk("t3.cg", rtv2, 128'd1);
        idle(1);
        chk("t3.bg", rtv2, {4{32'd1}});
        idle(5);

        // Back-to-back throughput from a fresh reset
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        issue(4'd1, 1'b0, 128'd3, 128'd4, 10'd0, 7'd1);
        issue(4'd2, 1'b0, 128'd1, 128'd9, 10'd0, 7'd2);
        chk("t4.add", rtv2, 128'd7);
        issue(4'd7, 1'b0, 128'd2, 128'd8, 10'd0, 7'd3);
        chk("t4.sf", rtv2, 128'd8);
        issue(4'd8, 1'b0, 128'd2, 128'd4, 10'd0, 7'd4);
        chk("t4.and", rtv2, 128'd0);
        chk("t4.and_wrt", 128'(wrt2), 128'd1);
        idle(1);
        chk("t4.andc", rtv2, 128'd2);
        idle(1);
        chk("t4.drain_wrt", 128'(wrt2), 128'd0);
        chk("t4.retired", 128'(ret2), 128'd4);
        idle(5);

        // Flush kills in-flight work and the concurrent input
        issue(4'd1, 1'b0, 128'd1, 128'd1, 10'd0, 7'd10);
        issue(4'd1, 1'b0, 128'd2, 128'd2, 10'd0, 7'd11);
        flush = 1'b1;
        issue(4'd1, 1'b0, 128'd5, 128'd5, 10'd0, 7'd12);
        chk("t5.flush_wrt", 128'(wrt2), 128'd0);
        chk("t5.flush_fv", 128'(fv2), 128'd0);
        idle(2);
        chk("t5.dropped_wrt", 128'(wrt2), 128'd0);
        issue(4'd1, 1'b0, 128'd6, 128'd7, 10'd0, 7'd13);
        idle(1);
        chk("t5.after_value", rtv2, 128'd13);
        idle(5);

        // Illegal op, alone and with flush
        issue(4'd12, 1'b0, 128'd1, 128'd1, 10'd0, 7'd14);
        chk("t5.illegal", 128'(ill2), 128'd1);
        chk("t5.illegal_fv", 128'(fv2[0]), 128'd0);
        idle(1);
        chk("t5.illegal_once", 128'(ill2), 128'd0);
        flush = 1'b1;
        issue(4'd13, 1'b0, 128'd1, 128'd1, 10'd0, 7'd15);
        chk("t5.illegal_flush", 128'(ill2), 128'd1);
        idle(5);

        // Asynchronous reset with work in flight
        issue(4'd1, 1'b0, 128'd1, 128'd2, 10'd0, 7'd21);
        issue(4'd1, 1'b0, 128'd3, 128'd4, 10'd0, 7'd22);
        in_valid = 1'b0;
        #2 reset = 1'b1;
        #1;
        chk("t6.async_wrt", 128'(wrt2), 128'd0);
        chk("t6.async_fv", 128'(fv2), 128'd0);
        chk("t6.async_value", rtv2, 128'd0);
        chk("t6.async_fv5", 128'(fv5), 128'd0);
        chk("t6.async_ret", 128'(ret2), 128'd0);
        @(negedge clock);
        reset = 1'b0;
        idle(2);
        chk("t6.no_wb", 128'(wrt2), 128'd0);
        issue(4'd1, 1'b0, 128'd8, 128'd9, 10'd0, 7'd23);
        idle(1);
        chk("t6.first_after", rtv2, 128'd17);

        // Retired wrap: preload then the pending write-back rolls it over
        #2;
        force dut_l2.r_retired = 32'hFFFF_FFFF;
        ret_exp[0] = 32'hFFFF_FFFF;
        #1;
        release dut_l2.r_retired;
        chk("t6.preload", 128'(ret2), 128'hFFFF_FFFF);
        @(negedge clock);
        chk("t6.wrap", 128'(ret2), 128'd0);
        idle(6);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
